// File: rtl/exec_mc_pkg.sv
// Shared definitions for the multi-cycle execution unit: opcodes, FSM states
// and the parameter sanity check used at elaboration.
package exec_mc_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDA  = 8'h01;
  localparam logic [7:0] OP_LDB  = 8'h02;
  localparam logic [7:0] OP_LDAB = 8'h03;
  localparam logic [7:0] OP_LDO  = 8'h04;
  localparam logic [7:0] OP_LDSA = 8'h05;
  localparam logic [7:0] OP_LDSB = 8'h06;
  localparam logic [7:0] OP_LSH  = 8'h07;
  localparam logic [7:0] OP_RSH  = 8'h08;
  localparam logic [7:0] OP_ADD  = 8'h09;
  localparam logic [7:0] OP_SUB  = 8'h0A;
  localparam logic [7:0] OP_AND  = 8'h0B;
  localparam logic [7:0] OP_OR   = 8'h0C;
  localparam logic [7:0] OP_XOR  = 8'h0D;
  localparam logic [7:0] OP_INV  = 8'h0E;
  localparam logic [7:0] OP_CLR  = 8'h0F;
  localparam logic [7:0] OP_ADDS = 8'h10;
  localparam logic [7:0] OP_SNZA = 8'h11;
  localparam logic [7:0] OP_SNZS = 8'h12;
  localparam logic [7:0] OP_MUL  = 8'h13;

  typedef enum logic [0:0] {ST_IDLE, ST_MUL} state_t;

  // The full product of two IN_WIDTH values must fit in the OUT_WIDTH registers.
  function automatic bit widths_ok(input int in_w, input int out_w);
    return out_w >= 2 * in_w;
  endfunction

endpackage

// File: rtl/exec_unit_mc_shift_add_mul.sv
// Sequential shift-add multiplier. The running sum lives in the caller's ACC;
// this block supplies the next partial sum each cycle and flags the last step.
module shift_add_mul #(
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [IN_WIDTH-1:0]  a,
  input  logic [IN_WIDTH-1:0]  b,
  input  logic [OUT_WIDTH-1:0] acc,
  output logic [OUT_WIDTH-1:0] product,
  output logic                 done
);

  localparam int CW = $clog2(IN_WIDTH + 1);

  logic [OUT_WIDTH-1:0] mcand;
  logic [IN_WIDTH-1:0]  mplier;
  logic [CW-1:0]        cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= OUT_WIDTH'(a);
      mplier <= b;
      cnt    <= CW'(IN_WIDTH);
    end else if (cnt != '0) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = (cnt == CW'(1));

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle execution unit: decoded-ROM instructions over valid/ready, with
// A/B/O/SR/ACC registers, sequential multiply and a skip request to the PC.
module exec_unit_mc
  import exec_mc_pkg::*;
#(
  parameter int IN_WIDTH     = 4,
  parameter int OUT_WIDTH    = 8,
  parameter int OPCODE_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [2*IN_WIDTH-1:0]   operand,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_valid,
  output logic                    skip,
  output logic                    overflow,
  output logic                    zero,
  output logic                    sf
);

  if (!widths_ok(IN_WIDTH, OUT_WIDTH)) begin : g_width_err
    $error("exec_unit_mc: OUT_WIDTH must be >= 2*IN_WIDTH");
  end

  state_t state, state_next;

  logic [IN_WIDTH-1:0]  a_reg, b_reg;
  logic [OUT_WIDTH-1:0] acc, o_reg, sr;
  logic [OUT_WIDTH-1:0] a_ext, b_ext, mul_product;
  logic [OUT_WIDTH:0]   sub_wide, adds_wide;
  logic                 accept, mul_start, mul_done;

  assign instr_ready = (state == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign mul_start   = accept && (opcode == OPCODE_WIDTH'(OP_MUL));

  assign a_ext     = OUT_WIDTH'(a_reg);
  assign b_ext     = OUT_WIDTH'(b_reg);
  assign sub_wide  = {1'b0, a_ext} - {1'b0, b_ext};
  assign adds_wide = {1'b0, acc} + {1'b0, sr};

  assign out_data = o_reg;
  assign zero     = (acc == '0);

  shift_add_mul #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (a_reg),
    .b      (b_reg),
    .acc    (acc),
    .product(mul_product),
    .done   (mul_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (mul_start) state_next = ST_MUL;
      ST_MUL:  if (mul_done)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // While multiplying, ACC takes the multiplier's partial sum every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      o_reg     <= '0;
      sr        <= '0;
      sf        <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      skip      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      skip      <= 1'b0;
      if (state == ST_MUL) begin
        acc <= mul_product;
      end else if (accept) begin
        case (opcode)
          OPCODE_WIDTH'(OP_LDA):  a_reg <= operand[2*IN_WIDTH-1:IN_WIDTH];
          OPCODE_WIDTH'(OP_LDB):  b_reg <= operand[IN_WIDTH-1:0];
          OPCODE_WIDTH'(OP_LDAB): begin
            a_reg <= operand[2*IN_WIDTH-1:IN_WIDTH];
            b_reg <= operand[IN_WIDTH-1:0];
          end
          OPCODE_WIDTH'(OP_LDO): begin
            o_reg     <= acc;
            out_valid <= 1'b1;
          end
          OPCODE_WIDTH'(OP_LDSA): sr <= a_ext;
          OPCODE_WIDTH'(OP_LDSB): sr <= b_ext;
          OPCODE_WIDTH'(OP_LSH): begin
            sf <= sr[OUT_WIDTH-1];
            sr <= sr << 1;
          end
          OPCODE_WIDTH'(OP_RSH): begin
            sf <= sr[0];
            sr <= sr >> 1;
          end
          OPCODE_WIDTH'(OP_ADD): begin
            acc      <= a_ext + b_ext;
            overflow <= 1'b0;
          end
          OPCODE_WIDTH'(OP_SUB): begin
            acc      <= sub_wide[OUT_WIDTH-1:0];
            overflow <= sub_wide[OUT_WIDTH];
          end
          OPCODE_WIDTH'(OP_AND):  acc <= a_ext & b_ext;
          OPCODE_WIDTH'(OP_OR):   acc <= a_ext | b_ext;
          OPCODE_WIDTH'(OP_XOR):  acc <= a_ext ^ b_ext;
          OPCODE_WIDTH'(OP_INV):  acc <= ~acc;
          OPCODE_WIDTH'(OP_CLR): begin
            acc      <= '0;
            overflow <= 1'b0;
          end
          OPCODE_WIDTH'(OP_ADDS): begin
            acc      <= adds_wide[OUT_WIDTH-1:0];
            overflow <= adds_wide[OUT_WIDTH];
          end
          OPCODE_WIDTH'(OP_SNZA): skip <= (a_reg != '0);
          OPCODE_WIDTH'(OP_SNZS): skip <= (sr != '0);
          OPCODE_WIDTH'(OP_MUL):  acc <= '0;
          default: ;
        endcase
      end
    end
  end

endmodule
